c64_debug_arbiter: RTL and testbench

C64_DEBUG_ARBITER -- requirements
Module: c64_debug_arbiter

---
 rtl/c64_pkg.sv | 13 +
 rtl/c64_debug_arbiter.sv | 112 +++++++++++
 tb/tb_c64_debug_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/c64_pkg.sv
// Shared types and defaults for the C64 debug-port bus arbiter.
package c64_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHalt,
    StOwn,
    StAck
  } arb_state_e;

  localparam int unsigned HaltMaxDefault = 4;

endpackage

// File: rtl/c64_debug_arbiter.sv
// Steals one C64 bus cycle for a debug-port access by halting the 6510 through RDY,
// forcing the access if the CPU keeps writing for HALT_MAX bus cycles.
module c64_debug_arbiter
  import c64_pkg::*;
#(
  parameter int unsigned HALT_MAX = HaltMaxDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        phi2_en,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_o,
  input  logic        cpu_we,
  input  logic [15:0] debug_addr,
  input  logic [7:0]  debug_data_o,
  input  logic        debug_we,
  input  logic        debug_request,
  input  logic [7:0]  bus_data_i,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_data_o,
  output logic        bus_we,
  output logic        cpu_rdy,
  output logic        debug_ack,
  output logic [7:0]  debug_data_i,
  output logic        debug_timeout
);

  arb_state_e  state_q, state_d;
  logic [2:0]  wait_cnt_q, wait_cnt_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        timeout_q, timeout_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      rdata_q    <= 8'h00;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rdata_q    <= rdata_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    rdata_d    = rdata_q;
    timeout_d  = timeout_q;
    unique case (state_q)
      StIdle: begin
        if (debug_request) begin
          state_d    = StHalt;
          wait_cnt_d = '0;
        end
      end
      StHalt: begin
        // A dropped request wins over a coincident phi2 strobe: nothing has touched the bus yet.
        if (!debug_request) begin
          state_d = StIdle;
        end else if (phi2_en) begin
          if (!cpu_we) begin
            state_d = StOwn;
          end else begin
            wait_cnt_d = wait_cnt_q + 3'd1;
            if ({29'd0, wait_cnt_q} + 32'd1 >= HALT_MAX) begin
              state_d   = StOwn;
              timeout_d = 1'b1;
            end
          end
        end
      end
      StOwn: begin
        if (phi2_en) begin
          if (!debug_we) rdata_d = bus_data_i;
          state_d = StAck;
        end
      end
      StAck: begin
        if (!debug_request) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs depend on the state register only, so cpu_rdy moves only on clk edges.
  always_comb begin
    cpu_rdy    = 1'b1;
    debug_ack  = 1'b0;
    bus_addr   = cpu_addr;
    bus_data_o = cpu_data_o;
    bus_we     = 1'b0;
    unique case (state_q)
      StIdle: ;
      StHalt: cpu_rdy = 1'b0;
      StOwn: begin
        cpu_rdy    = 1'b0;
        bus_addr   = debug_addr;
        bus_data_o = debug_data_o;
        bus_we     = debug_we;
      end
      StAck: debug_ack = 1'b1;
      default: ;
    endcase
  end

  assign debug_data_i  = rdata_q;
  assign debug_timeout = timeout_q;

endmodule

// File: tb/tb_c64_debug_arbiter.sv
// Self-checking bench for c64_debug_arbiter: directed scenarios plus randomized accesses
// checked against a transaction-level model of halt length, ownership and returned data.
module tb_c64_debug_arbiter;

  localparam int HALT_MAX = 4;
  localparam int CLKS_PER_BUS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        phi2_en;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_o;
  logic        cpu_we;
  logic [15:0] debug_addr;
  logic [7:0]  debug_data_o;
  logic        debug_we;
  logic        debug_request;
  logic [7:0]  bus_data_i;
  logic [15:0] bus_addr;
  logic [7:0]  bus_data_o;
  logic        bus_we;
  logic        cpu_rdy;
  logic        debug_ack;
  logic [7:0]  debug_data_i;
  logic        debug_timeout;

  int checks = 0;
  int errors = 0;
  int phase = 0;
  logic [7:0] model_rdata = 8'h00;
  logic       model_timeout = 1'b0;

  c64_debug_arbiter #(.HALT_MAX(HALT_MAX)) dut (
    .clk          (clk),
    .reset        (reset),
    .phi2_en      (phi2_en),
    .cpu_addr     (cpu_addr),
    .cpu_data_o   (cpu_data_o),
    .cpu_we       (cpu_we),
    .debug_addr   (debug_addr),
    .debug_data_o (debug_data_o),
    .debug_we     (debug_we),
    .debug_request(debug_request),
    .bus_data_i   (bus_data_i),
    .bus_addr     (bus_addr),
    .bus_data_o   (bus_data_o),
    .bus_we       (bus_we),
    .cpu_rdy      (cpu_rdy),
    .debug_ack    (debug_ack),
    .debug_data_i (debug_data_i),
    .debug_timeout(debug_timeout)
  );

  always #5 clk = ~clk;

  // phi2_en is high for the last clk of every 4-clk bus cycle.
  task automatic step();
    @(posedge clk);
    #1;
    phase   = (phase + 1) % CLKS_PER_BUS;
    phi2_en = (phase == CLKS_PER_BUS - 1);
  endtask

  task automatic align(input int p);
    while (phase != p) step();
  endtask

  // Runs one debug access; cpu_we is 1 for the first n_we1 bus cycles counted from the request.
  task automatic run_access(input logic [15:0] addr, input logic [7:0] wd, input logic we,
                            input logic [7:0] rd, input int n_we1, input int hold,
                            input bit drop_in_own, output int own_clks, output int halt_we1,
                            output int ack_clks, output int bad_we, output int rdy_bad,
                            output int rdy_lat, output logic [7:0] rdata, output bit done);
    int bus_idx;
    logic pre_phi, pre_rdy, pre_own, pre_we;
    own_clks = 0; halt_we1 = 0; ack_clks = 0; bad_we = 0; rdy_bad = 0;
    rdy_lat = -1; rdata = 8'hxx; done = 0; bus_idx = 0;
    cpu_addr      = addr ^ 16'h8000;
    cpu_data_o    = ~wd;
    debug_addr    = addr;
    debug_data_o  = wd;
    debug_we      = we;
    bus_data_i    = rd;
    cpu_we        = (n_we1 > 0);
    debug_request = 1'b1;
    for (int s = 0; s < 400 && !done; s++) begin
      pre_phi = phi2_en;
      pre_rdy = cpu_rdy;
      pre_own = (bus_addr == addr);
      pre_we  = cpu_we;
      step();
      if (pre_phi && !pre_rdy && !pre_own && pre_we) halt_we1++;
      if (phase == 0) begin
        bus_idx++;
        cpu_we = (bus_idx < n_we1);
      end
      if (rdy_lat < 0 && !cpu_rdy) rdy_lat = s + 1;
      if (bus_addr == addr) begin
        own_clks++;
        if (cpu_rdy) rdy_bad++;
        if (drop_in_own) debug_request = 1'b0;
        if (bus_we !== we || (we && bus_data_o !== wd)) bad_we++;
      end else if (bus_we !== 1'b0) begin
        bad_we++;
      end
      if (debug_ack) begin
        ack_clks++;
        rdata = debug_data_i;
        if (!cpu_rdy) rdy_bad++;
        if (ack_clks > hold) debug_request = 1'b0;
      end else if (ack_clks > 0) begin
        done = 1;
        if (!cpu_rdy) rdy_bad++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; phi2_en = 1'b0; cpu_addr = 16'hC000; cpu_data_o = 8'hAA; cpu_we = 1'b1;
    debug_addr = 16'h1000; debug_data_o = 8'h55; debug_we = 1'b1; debug_request = 1'b0;
    bus_data_i = 8'hFF;
    step(); step(); step();
    checks++;
    if (cpu_rdy !== 1'b1 || debug_ack !== 1'b0 || debug_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl rdy=%b ack=%b to=%b want 1 0 0", cpu_rdy, debug_ack,
               debug_timeout);
    end
    checks++;
    if (debug_data_i !== 8'h00) begin
      errors++; $display("FAIL reset_data got %h want 00", debug_data_i);
    end
    checks++;
    if (bus_addr !== 16'hC000 || bus_data_o !== 8'hAA || bus_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_bus got %h/%h/%b want c000/aa/0", bus_addr, bus_data_o, bus_we);
    end
    reset = 1'b0;
    step(); step();
  endtask

  task automatic test_read_d020();
    int own, hw, ackc, bad, rb, lat; logic [7:0] rdat; bit done;
    align(0);
    run_access(16'hD020, 8'h00, 1'b0, 8'h0E, 0, 1, 1'b0, own, hw, ackc, bad, rb, lat, rdat,
               done);
    model_rdata = 8'h0E;
    checks++;
    if (done !== 1'b1 || lat !== 1) begin
      errors++; $display("FAIL read_start done=%b rdy_latency=%0d want 1 1", done, lat);
    end
    checks++;
    if (own !== 4 || bad !== 0 || rb !== 0) begin
      errors++;
      $display("FAIL read_own clks=%0d bad_we=%0d rdy_bad=%0d want 4 0 0", own, bad, rb);
    end
    checks++;
    if (rdat !== 8'h0E || ackc !== 2) begin
      errors++; $display("FAIL read_data got %h ack=%0d want 0e 2", rdat, ackc);
    end
  endtask

  task automatic test_write_burst();
    int own, hw, ackc, bad, rb, lat; logic [7:0] rdat; bit done;
    align(0);
    run_access(16'h0400, 8'h41, 1'b1, 8'h99, 3, 0, 1'b0, own, hw, ackc, bad, rb, lat, rdat,
               done);
    checks++;
    if (done !== 1'b1 || hw !== 3) begin
      errors++; $display("FAIL write_halt done=%b halt_cycles=%0d want 1 3", done, hw);
    end
    checks++;
    if (own !== 4 || bad !== 0) begin
      errors++; $display("FAIL write_own clks=%0d bad_we=%0d want 4 0", own, bad);
    end
    checks++;
    if (debug_timeout !== 1'b0 || rdat !== model_rdata) begin
      errors++;
      $display("FAIL write_flags to=%b data=%h want 0 %h", debug_timeout, rdat, model_rdata);
    end
  endtask

  task automatic test_abort();
    int n; bit leaked;
    align(0);
    n = $urandom_range(1, 10);
    leaked = 0;
    cpu_addr = 16'h2000; debug_addr = 16'h3000; debug_we = 1'b1; cpu_we = 1'b1;
    debug_request = 1'b1;
    step();
    checks++;
    if (cpu_rdy !== 1'b0) begin
      errors++; $display("FAIL abort_halt rdy=%b want 0", cpu_rdy);
    end
    for (int k = 1; k < n; k++) begin
      step();
      if (bus_addr === 16'h3000 || debug_ack !== 1'b0 || bus_we !== 1'b0) leaked = 1;
    end
    debug_request = 1'b0;
    step();
    checks++;
    if (cpu_rdy !== 1'b1 || debug_ack !== 1'b0) begin
      errors++; $display("FAIL abort_release rdy=%b ack=%b want 1 0", cpu_rdy, debug_ack);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      if (bus_addr === 16'h3000 || debug_ack !== 1'b0 || cpu_rdy !== 1'b1) leaked = 1;
    end
    checks++;
    if (leaked !== 1'b0) begin
      errors++; $display("FAIL abort_no_access leaked=%b want 0", leaked);
    end
  endtask

  task automatic test_forced();
    int own, hw, ackc, bad, rb, lat; logic [7:0] rdat; bit done;
    align(1);
    run_access(16'hDC00, 8'h7F, 1'b1, 8'h12, 10, 0, 1'b0, own, hw, ackc, bad, rb, lat, rdat,
               done);
    model_timeout = 1'b1;
    checks++;
    if (done !== 1'b1 || hw !== HALT_MAX || own !== 4) begin
      errors++;
      $display("FAIL forced_halt done=%b halt=%0d own=%0d want 1 %0d 4", done, hw, own,
               HALT_MAX);
    end
    repeat (20) step();
    checks++;
    if (debug_timeout !== 1'b1) begin
      errors++; $display("FAIL forced_sticky to=%b want 1", debug_timeout);
    end
  endtask

  task automatic test_drop_in_own();
    int own, hw, ackc, bad, rb, lat; logic [7:0] rdat; bit done;
    align(2);
    run_access(16'hA5A5, 8'h00, 1'b0, 8'hC3, 1, 3, 1'b1, own, hw, ackc, bad, rb, lat, rdat,
               done);
    model_rdata = 8'hC3;
    checks++;
    if (done !== 1'b1 || own !== 4 || ackc !== 1 || rdat !== 8'hC3) begin
      errors++;
      $display("FAIL drop_own done=%b own=%0d ack=%0d data=%h want 1 4 1 c3", done, own, ackc,
               rdat);
    end
  endtask

  task automatic test_reset_mid_own();
    int own, hw, ackc, bad, rb, lat; logic [7:0] rdat; bit done; bit seen;
    align(0);
    cpu_addr = 16'h1234; debug_addr = 16'hD021; debug_we = 1'b0; bus_data_i = 8'h55;
    cpu_we = 1'b0; debug_request = 1'b1;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      if (bus_addr === 16'hD021) seen = 1;
    end
    checks++;
    if (seen !== 1'b1) begin
      errors++; $display("FAIL rst_own_reach seen=%b want 1", seen);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (cpu_rdy !== 1'b1 || debug_ack !== 1'b0 || debug_data_i !== 8'h00 ||
        bus_addr !== 16'h1234 || debug_timeout !== 1'b0) begin
      errors++;
      $display("FAIL rst_own rdy=%b ack=%b data=%h addr=%h to=%b want 1 0 00 1234 0", cpu_rdy,
               debug_ack, debug_data_i, bus_addr, debug_timeout);
    end
    debug_request = 1'b0;
    step(); step();
    reset = 1'b0;
    model_rdata = 8'h00;
    model_timeout = 1'b0;
    step();
    align(0);
    run_access(16'hD020, 8'h00, 1'b0, 8'h0E, 0, 0, 1'b0, own, hw, ackc, bad, rb, lat, rdat,
               done);
    model_rdata = 8'h0E;
    checks++;
    if (done !== 1'b1 || rdat !== 8'h0E || own !== 4 || debug_timeout !== 1'b0) begin
      errors++;
      $display("FAIL rst_recover done=%b data=%h own=%0d to=%b want 1 0e 4 0", done, rdat, own,
               debug_timeout);
    end
  endtask

  task automatic test_random();
    int own, hw, ackc, bad, rb, lat, n, hold, exp_halt, exp_ack;
    logic [7:0] rdat, wd, rd, exp_rd; logic [15:0] addr; logic we; bit done, drop;
    for (int i = 0; i < 24; i++) begin
      addr = 16'($urandom); wd = 8'($urandom); rd = 8'($urandom);
      we = 1'($urandom_range(0, 1)); n = $urandom_range(0, 6);
      hold = $urandom_range(0, 3); drop = ($urandom_range(0, 3) == 0);
      align($urandom_range(0, 2));
      run_access(addr, wd, we, rd, n, hold, drop, own, hw, ackc, bad, rb, lat, rdat, done);
      exp_halt = (n < HALT_MAX) ? n : HALT_MAX;
      if (n >= HALT_MAX) model_timeout = 1'b1;
      exp_rd = we ? model_rdata : rd;
      model_rdata = exp_rd;
      exp_ack = drop ? 1 : hold + 1;
      checks++;
      if (done !== 1'b1 || own !== 4 || hw !== exp_halt || ackc !== exp_ack || bad !== 0 ||
          rb !== 0 || lat !== 1) begin
        errors++;
        $display("FAIL rand%0d_seq done=%b own=%0d halt=%0d ack=%0d bad=%0d rb=%0d lat=%0d want 1 4 %0d %0d 0 0 1",
                 i, done, own, hw, ackc, bad, rb, lat, exp_halt, exp_ack);
      end
      checks++;
      if (rdat !== exp_rd || debug_timeout !== model_timeout) begin
        errors++;
        $display("FAIL rand%0d_result data=%h to=%b want %h %b", i, rdat, debug_timeout,
                 exp_rd, model_timeout);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_d020();
    test_write_burst();
    test_abort();
    test_forced();
    test_drop_in_own();
    test_reset_mid_own();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
